// File: rtl/xdma_axis_pkt_rr_mux.sv
// ============================================================================
// xdma_axis_pkt_rr_mux : packet-atomic round-robin AXI-Stream N:1 mux with a
//                        2-entry output skid buffer and per-channel counters.
// Revision 1.0
// ============================================================================
`default_nettype none

module xdma_axis_pkt_rr_mux #(
   parameter int CH_NUM       = 2,
   parameter int TDATA_WIDTH  = 512,
   parameter int TKEEP_WIDTH  = TDATA_WIDTH / 8,
   parameter int TUSER_WIDTH  = 1,
   parameter int CH_IDX_WIDTH = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                          xdma_clk,
   input  logic                          xdma_reset,
   input  logic [CH_NUM-1:0]             ch_enable,
   input  logic [CH_NUM-1:0]             s_axis_tvalid,
   output logic [CH_NUM-1:0]             s_axis_tready,
   input  logic [CH_NUM-1:0]             s_axis_tlast,
   input  logic [CH_NUM*TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CH_NUM*TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [CH_NUM*TUSER_WIDTH-1:0] s_axis_tuser,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0]        m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]        m_axis_tuser,
   output logic [CH_IDX_WIDTH-1:0]       m_axis_tid,
   output logic [CH_NUM*16-1:0]          pkt_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [CH_IDX_WIDTH-1:0] r_last, r_lock;
   logic [CH_IDX_WIDTH-1:0] w_scan, w_rr_idx, w_sel;
   logic                    w_rr_vld, w_sel_vld, w_sel_last;
   logic                    w_space, w_accept, w_pop, w_pkt_done;

   logic [TDATA_WIDTH-1:0]  w_ch_data [CH_NUM];
   logic [TKEEP_WIDTH-1:0]  w_ch_keep [CH_NUM];
   logic [TUSER_WIDTH-1:0]  w_ch_user [CH_NUM];

   logic [TDATA_WIDTH-1:0]  r_buf_data [2];
   logic [TKEEP_WIDTH-1:0]  r_buf_keep [2];
   logic [TUSER_WIDTH-1:0]  r_buf_user [2];
   logic                    r_buf_last [2];
   logic [CH_IDX_WIDTH-1:0] r_buf_tid  [2];
   logic                    r_wr_ptr, r_rd_ptr;
   logic [1:0]              r_count;

   // Space is judged on the registered fill level only, so s_axis_tready
   // never sees m_axis_tready combinationally.
   assign w_space    = (r_count != 2'd2);
   assign w_pop      = m_axis_tready & (r_count != 2'd0);
   assign w_sel_last = s_axis_tlast[w_sel];
   assign w_accept   = w_sel_vld & w_space & s_axis_tvalid[w_sel];
   assign w_pkt_done = w_accept & w_sel_last;

   // Round-robin scan; the lowest offset from last_grant is written last and wins.
   always_comb begin
      w_rr_vld = 1'b0;
      w_rr_idx = '0;
      w_scan   = '0;
      for (int k = CH_NUM; k >= 1; k--) begin
         w_scan = CH_IDX_WIDTH'((int'(r_last) + k) % CH_NUM);
         if (ch_enable[w_scan] & s_axis_tvalid[w_scan]) begin
            w_rr_vld = 1'b1;
            w_rr_idx = w_scan;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel       = r_lock;
      w_sel_vld   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_sel     = w_rr_idx;
            w_sel_vld = w_rr_vld;
            if (w_accept && !w_sel_last)
               w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: begin
            w_sel_vld = 1'b1;
            if (w_pkt_done)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready = '0;
      if (w_sel_vld && w_space && !xdma_reset)
         s_axis_tready[w_sel] = 1'b1;
   end

   always_ff @(posedge xdma_clk or posedge xdma_reset) begin
      if (xdma_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge xdma_clk or posedge xdma_reset) begin
      if (xdma_reset) begin
         r_last <= CH_IDX_WIDTH'(CH_NUM - 1);
         r_lock <= '0;
      end else if (w_accept) begin
         r_lock <= w_sel;
         if (w_sel_last)
            r_last <= w_sel;
      end
   end

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [15:0] r_pkt_cnt;

      assign w_ch_data[gi] = s_axis_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
      assign w_ch_keep[gi] = s_axis_tkeep[gi*TKEEP_WIDTH +: TKEEP_WIDTH];
      assign w_ch_user[gi] = s_axis_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH];
      assign pkt_cnt[gi*16 +: 16] = r_pkt_cnt;

      always_ff @(posedge xdma_clk or posedge xdma_reset) begin
         if (xdma_reset)
            r_pkt_cnt <= '0;
         else if (w_pkt_done && (w_sel == CH_IDX_WIDTH'(gi)))
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
   end

   always_ff @(posedge xdma_clk or posedge xdma_reset) begin
      if (xdma_reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int e = 0; e < 2; e++) begin
            r_buf_data[e] <= '0;
            r_buf_keep[e] <= '0;
            r_buf_user[e] <= '0;
            r_buf_last[e] <= 1'b0;
            r_buf_tid[e]  <= '0;
         end
      end else begin
         if (w_accept) begin
            r_buf_data[r_wr_ptr] <= w_ch_data[w_sel];
            r_buf_keep[r_wr_ptr] <= w_ch_keep[w_sel];
            r_buf_user[r_wr_ptr] <= w_ch_user[w_sel];
            r_buf_last[r_wr_ptr] <= w_sel_last;
            r_buf_tid[r_wr_ptr]  <= w_sel;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign m_axis_tvalid = (r_count != 2'd0);
   assign m_axis_tdata  = r_buf_data[r_rd_ptr];
   assign m_axis_tkeep  = r_buf_keep[r_rd_ptr];
   assign m_axis_tuser  = r_buf_user[r_rd_ptr];
   assign m_axis_tlast  = r_buf_last[r_rd_ptr];
   assign m_axis_tid    = r_buf_tid[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_xdma_axis_pkt_rr_mux.sv
// ============================================================================
// tb_xdma_axis_pkt_rr_mux : self-checking bench for the packet round-robin mux.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_xdma_axis_pkt_rr_mux;

   logic        xdma_clk, xdma_reset;
   logic [3:0]  en, vld, lst;
   logic        mrdy;
   logic [31:0] dat [4];
   logic [3:0]  kp  [4];
   logic [1:0]  us  [4];

   logic [3:0]  s_axis_tready;
   logic        m_axis_tvalid, m_axis_tlast;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic [1:0]  m_axis_tuser;
   logic [1:0]  m_axis_tid;
   logic [63:0] pkt_cnt;

   xdma_axis_pkt_rr_mux #(
      .CH_NUM(4), .TDATA_WIDTH(32), .TKEEP_WIDTH(4), .TUSER_WIDTH(2), .CH_IDX_WIDTH(2)
   ) dut (
      .xdma_clk      (xdma_clk),
      .xdma_reset    (xdma_reset),
      .ch_enable     (en),
      .s_axis_tvalid (vld),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (lst),
      .s_axis_tdata  ({dat[3], dat[2], dat[1], dat[0]}),
      .s_axis_tkeep  ({kp[3], kp[2], kp[1], kp[0]}),
      .s_axis_tuser  ({us[3], us[2], us[1], us[0]}),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (mrdy),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tid    (m_axis_tid),
      .pkt_cnt       (pkt_cnt)
   );

   initial xdma_clk = 1'b0;
   always #5 xdma_clk = ~xdma_clk;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: beats in flight held in a queue, arbitration from the rules.
   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic [1:0]  u;
      logic        l;
      logic [1:0]  id;
   } beat_t;

   beat_t       mq[$];
   int          own, lastg, acc_ch;
   logic [15:0] mcnt [4];

   task automatic model_reset();
      mq.delete();
      own    = -1;
      lastg  = 3;
      acc_ch = -1;
      for (int i = 0; i < 4; i++) mcnt[i] = 16'd0;
   endtask

   task automatic model_cycle();
      int         g, idx;
      logic [3:0] erdy;
      beat_t      b;
      g = -1;
      if (own >= 0) g = own;
      else begin
         for (int k = 1; k <= 4; k++) begin
            idx = (lastg + k) % 4;
            if (g < 0 && vld[idx] && en[idx]) g = idx;
         end
      end
      erdy = '0;
      if (g >= 0 && mq.size() < 2) erdy[g] = 1'b1;
      chk("model_tready", s_axis_tready, erdy);
      chk("model_mvalid", m_axis_tvalid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("model_tdata", m_axis_tdata, mq[0].d);
         chk("model_tkeep", m_axis_tkeep, mq[0].k);
         chk("model_tuser", m_axis_tuser, mq[0].u);
         chk("model_tlast", m_axis_tlast, mq[0].l);
         chk("model_tid",   m_axis_tid,   mq[0].id);
      end
      for (int i = 0; i < 4; i++) chk("model_pkt_cnt", pkt_cnt[i*16 +: 16], mcnt[i]);
      acc_ch = -1;
      if (erdy != 4'b0) begin
         if (vld[g]) acc_ch = g;
      end
      if (mrdy && mq.size() > 0) void'(mq.pop_front());
      if (acc_ch >= 0) begin
         b.d = dat[g]; b.k = kp[g]; b.u = us[g]; b.l = lst[g]; b.id = 2'(g);
         mq.push_back(b);
         if (lst[g]) begin
            mcnt[g] = mcnt[g] + 16'd1;
            lastg   = g;
            own     = -1;
         end else begin
            own = g;
         end
      end
   endtask

   task automatic advance();
      @(posedge xdma_clk);
      #1;
      if (acc_ch >= 0) begin
         dat[acc_ch] = $urandom;
         kp[acc_ch]  = 4'($urandom);
         us[acc_ch]  = 2'($urandom);
      end
   endtask

   task automatic step();
      #4;
      model_cycle();
      advance();
   endtask

   task automatic step_rdy(input logic [3:0] e_rdy, input string nm);
      #4;
      chk(nm, s_axis_tready, e_rdy);
      model_cycle();
      advance();
   endtask

   task automatic do_reset();
      xdma_reset = 1'b1;
      en = 4'hF; vld = 4'hF; lst = 4'h0; mrdy = 1'b1;
      #2;
      chk("rst_mvalid", m_axis_tvalid, 1'b0);
      chk("rst_mlast",  m_axis_tlast,  1'b0);
      chk("rst_tid",    m_axis_tid,    2'd0);
      chk("rst_tready", s_axis_tready, 4'h0);
      chk("rst_pktcnt", pkt_cnt,       64'd0);
      @(posedge xdma_clk);
      #1;
      vld = 4'h0;
      xdma_reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  en, vld, lst;
      logic        mrdy;
      logic [3:0]  e_rdy;
      logic        e_mv;
      logic [1:0]  e_tid;
      logic        e_last;
      logic [15:0] e_dat, e_pc0, e_pc1;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #2_000_000;
      miscompares++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      int rem [4];
      int pat [12];
      int sent, outn, n, guard;
      logic        was_stall;
      logic [31:0] held;

      // Two channels with 3-beat packets, then ch_enable cleared mid-packet.
      tbl[0]  = '{1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 16'h0000, 16'd0, 16'd0};
      tbl[1]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h0000, 16'd0, 16'd0};
      tbl[2]  = '{1'b0, 4'b0011, 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h0001, 16'd0, 16'd0};
      tbl[3]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1, 16'h0002, 16'd1, 16'd0};
      tbl[4]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0103, 16'd1, 16'd0};
      tbl[5]  = '{1'b0, 4'b0011, 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0104, 16'd1, 16'd0};
      tbl[6]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1, 16'h0105, 16'd1, 16'd1};
      tbl[7]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h0006, 16'd1, 16'd1};
      tbl[8]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h0007, 16'd1, 16'd1};
      tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 16'h0008, 16'd2, 16'd1};
      tbl[10] = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'd2, 16'd1};
      tbl[11] = '{1'b1, 4'b0001, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 16'h0000, 16'd0, 16'd0};
      tbl[12] = '{1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h000B, 16'd0, 16'd0};
      tbl[13] = '{1'b0, 4'b0000, 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h000C, 16'd0, 16'd0};
      tbl[14] = '{1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 16'h000D, 16'd1, 16'd0};
      tbl[15] = '{1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'd1, 16'd0};

      xdma_reset = 1'b1;
      en = '0; vld = '0; lst = '0; mrdy = 1'b0;
      for (int i = 0; i < 4; i++) begin dat[i] = '0; kp[i] = '0; us[i] = '0; end
      model_reset();
      @(posedge xdma_clk);
      #1;

      for (int r = 0; r < 16; r++) begin
         if (tbl[r].rst) do_reset();
         en = tbl[r].en; vld = tbl[r].vld; lst = tbl[r].lst; mrdy = tbl[r].mrdy;
         for (int i = 0; i < 4; i++) begin
            dat[i] = 32'(i * 256 + r); kp[i] = 4'hF; us[i] = 2'd0;
         end
         #4;
         chk("tbl_tready", s_axis_tready, tbl[r].e_rdy);
         chk("tbl_mvalid", m_axis_tvalid, tbl[r].e_mv);
         if (tbl[r].e_mv) begin
            chk("tbl_tid",   m_axis_tid,   tbl[r].e_tid);
            chk("tbl_tlast", m_axis_tlast, tbl[r].e_last);
            chk("tbl_tdata", m_axis_tdata, 64'(tbl[r].e_dat));
         end
         chk("tbl_pktcnt0", pkt_cnt[15:0],  tbl[r].e_pc0);
         chk("tbl_pktcnt1", pkt_cnt[31:16], tbl[r].e_pc1);
         model_cycle();
         advance();
      end

      // Channel 0 waits out channel 1's 4-beat packet, then wins next.
      do_reset();
      en = 4'hF; lst = 4'h0; vld = 4'b0010;
      step_rdy(4'b0010, "lock_beat1");
      vld = 4'b0011;
      step_rdy(4'b0010, "lock_beat2");
      step_rdy(4'b0010, "lock_beat3");
      lst = 4'b0010;
      step_rdy(4'b0010, "lock_beat4");
      chk("lock_cnt1", pkt_cnt[31:16], 16'd1);
      vld = 4'b0001; lst = 4'b0001;
      step_rdy(4'b0001, "lock_ch0_next");
      vld = 4'h0; lst = 4'h0;
      step(); step();

      // Output back-pressure 1,1,0,0,1... on one 4-beat packet.
      do_reset();
      en = 4'b0001;
      pat = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      sent = 0; outn = 0; was_stall = 1'b0; held = '0;
      for (int c = 0; c < 12; c++) begin
         mrdy = pat[c][0];
         vld[0] = (sent < 4);
         lst[0] = (sent == 3);
         #4;
         if (was_stall) chk("bp_hold", m_axis_tdata, held);
         if (c == 3) chk("bp_full", s_axis_tready, 4'h0);
         was_stall = m_axis_tvalid && !mrdy;
         held = m_axis_tdata;
         if (m_axis_tvalid && mrdy) outn++;
         model_cycle();
         if (acc_ch == 0) sent++;
         advance();
      end
      chk("bp_beats_out", 64'(outn), 64'd4);

      // Asynchronous reset in the middle of a channel-1 packet.
      do_reset();
      en = 4'hF; mrdy = 1'b1;
      vld = 4'b0001; lst = 4'b0001;
      step();
      vld = 4'b0010; lst = 4'b0000;
      step(); step();
      chk("arst_pre_mvalid", m_axis_tvalid, 1'b1);
      #2;
      xdma_reset = 1'b1;
      #1;
      chk("arst_mvalid", m_axis_tvalid, 1'b0);
      chk("arst_pktcnt", pkt_cnt, 64'd0);
      chk("arst_tready", s_axis_tready, 4'h0);
      @(posedge xdma_clk);
      #1;
      xdma_reset = 1'b0;
      model_reset();
      vld = 4'b0011; lst = 4'b0001;
      step_rdy(4'b0001, "arst_first_grant");
      vld = 4'b0010; lst = 4'b0000;
      step();
      lst = 4'b0010;
      step();
      vld = 4'h0; lst = 4'h0;
      step(); step();

      // Randomized traffic against the reference model.
      do_reset();
      en = 4'hF;
      for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 4);
      for (int c = 0; c < 2000; c++) begin
         mrdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) en = 4'($urandom);
         for (int i = 0; i < 4; i++) lst[i] = (rem[i] == 1);
         step();
         for (int i = 0; i < 4; i++) begin
            if (acc_ch == i) begin
               rem[i]--;
               if (rem[i] == 0) begin
                  rem[i] = $urandom_range(1, 4);
                  vld[i] = ($urandom_range(0, 2) != 0);
               end
            end else if (!vld[i]) begin
               vld[i] = ($urandom_range(0, 3) == 0);
            end
         end
      end

      // 65537 single-beat packets on channel 3: counter wraps to 1.
      do_reset();
      en = 4'b1000; vld = 4'b1000; lst = 4'b1000; mrdy = 1'b1;
      n = 0; guard = 0;
      while (n < 65537 && guard < 70000) begin
         step();
         if (acc_ch == 3) n++;
         guard++;
      end
      chk("wrap_accepts", 64'(n), 64'd65537);
      vld = 4'h0; lst = 4'h0;
      step(); step();
      chk("wrap_cnt3", pkt_cnt[63:48], 16'd1);
      chk("wrap_cnt2", pkt_cnt[47:32], 16'd0);
      chk("wrap_cnt1", pkt_cnt[31:16], 16'd0);
      chk("wrap_cnt0", pkt_cnt[15:0],  16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
